// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit sequencer state encoding, byte width and
// the system-wide baud / system clock defaults.
package uart_pkg;

    localparam int BYTE_W       = 8;
    localparam int SYS_CLK_HZ   = 100_000_000;
    localparam int BAUD_RATE    = 19_200;
    localparam int CLKS_PER_BIT = SYS_CLK_HZ / BAUD_RATE;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-derived full/empty and a sticky overflow flag.
// Storage has no reset; only pointers, count and flags are cleared by rst.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  push_ok, pop_ok;

    // full is taken from registered state, so a pop never frees a slot for a
    // write in the same cycle.
    assign push_ok = wr_en && !full_q;
    assign pop_ok  = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (wr_en & full_q);
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = mem[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue plus transmit sequencer feeding a uart transmitter.
// Optional flow control: define UART_TX_FIFO_CTS_EN to add the cts_n input.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2    = 4,
    parameter int START_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [BYTE_W-1:0]     wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  transmit,
    output logic [BYTE_W-1:0]     tx_byte,
    input  logic                  is_transmitting,
`ifdef UART_TX_FIFO_CTS_EN
    input  logic                  cts_n,
`endif
    output logic                  busy
);

    localparam int TW = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT + 1);

    tx_state_e         state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic              transmit_q, transmit_d;
    logic [BYTE_W-1:0] rd_data;
    logic              pop;
    logic              fifo_empty;
    logic              cts_ok;

    sync_fifo #(
        .WIDTH      (BYTE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (fifo_empty),
        .count    (count),
        .overflow (overflow)
    );

`ifdef UART_TX_FIFO_CTS_EN
    logic [1:0] cts_sync_q, cts_sync_d;

    assign cts_sync_d = {cts_sync_q[0], cts_n};
    assign cts_ok     = !cts_sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cts_sync_q <= 2'b11;
        else     cts_sync_q <= cts_sync_d;
    end
`else
    assign cts_ok = 1'b1;
`endif

    // transmit is registered, so the pulse appears the cycle after LOAD.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        tx_byte_d  = tx_byte_q;
        transmit_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && cts_ok) begin
                    pop       = 1'b1;
                    tx_byte_d = rd_data;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                transmit_d = 1'b1;
                timer_d    = '0;
                state_d    = WAIT_START;
            end
            WAIT_START: begin
                if (is_transmitting)                    state_d = WAIT_DONE;
                else if (timer_q == TW'(START_TIMEOUT)) state_d = LOAD;
                else                                    timer_d = timer_q + 1'b1;
            end
            WAIT_DONE: begin
                if (!is_transmitting) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            tx_byte_q  <= '0;
            transmit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            tx_byte_q  <= tx_byte_d;
            transmit_q <= transmit_d;
        end
    end

    assign transmit = transmit_q;
    assign tx_byte  = tx_byte_q;
    assign empty    = fifo_empty;
    assign busy     = (state_q != IDLE);

endmodule
